// File: rtl/imem_load_arbiter_if.sv
// imem_load_arbiter_if: loader, CPU fetch and instruction-RAM signals
// shared by the arbiter (slave) and its surroundings (master).
interface imem_load_arbiter_if #(
  parameter int ADDR_W = 5
);
  logic              ld_mode;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              ld_wrap;
  logic [7:0]        ld_checksum;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic              cpu_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output ld_mode, ld_valid, ld_byte,
    output fetch_req, fetch_addr, mem_rdata,
    input  ld_ready, ld_wrap, ld_checksum,
    input  fetch_ready, fetch_valid, fetch_data,
    input  cpu_stall, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_mode, ld_valid, ld_byte,
    input  fetch_req, fetch_addr, mem_rdata,
    output ld_ready, ld_wrap, ld_checksum,
    output fetch_ready, fetch_valid, fetch_data,
    output cpu_stall, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the instruction RAM between CPU fetch and the
// byte-serial loader. IMEM_ARB_CHECKSUM_EN enables the session checksum.
module imem_load_arbiter #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  imem_load_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WRITE, FLUSH
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_cnt;
  logic [31:0]       word;
  logic [31:0]       fetch_q;
  logic              wrap;

  logic              accept;
  logic              sess;
  logic              wr_fire;
  logic              busy;
  logic              ld_ready;
  logic              fetch_ready;
  logic              fetch_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       fetch_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    sess        = 1'b0;
    wr_fire     = 1'b0;
    ld_ready    = 1'b0;
    fetch_ready = 1'b0;
    fetch_valid = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = wr_ptr;
    mem_wdata   = '0;
    fetch_data  = fetch_q;
    unique case (state)
      IDLE: begin
        if (bus.ld_mode) begin
          state_n = LOAD;
          sess    = 1'b1;
        end else if (bus.fetch_req) begin
          state_n     = FETCH;
          fetch_ready = 1'b1;
          mem_addr    = bus.fetch_addr;
        end
      end
      FETCH: begin
        fetch_valid = 1'b1;
        fetch_data  = bus.mem_rdata;
        if (bus.ld_mode) begin
          state_n = LOAD;
          sess    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (!bus.ld_mode) begin
          state_n = (byte_cnt != 2'd0) ? FLUSH : IDLE;
        end else begin
          ld_ready = 1'b1;
          if (bus.ld_valid) begin
            accept = 1'b1;
            if (byte_cnt == 2'd3) state_n = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = word;
        wr_fire   = 1'b1;
        state_n   = bus.ld_mode ? LOAD : IDLE;
      end
      FLUSH: begin
        mem_we    = 1'b1;
        mem_wdata = word;
        wr_fire   = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // reset silences every output and squashes any pending write
    if (rst) begin
      state_n     = IDLE;
      accept      = 1'b0;
      sess        = 1'b0;
      wr_fire     = 1'b0;
      ld_ready    = 1'b0;
      fetch_ready = 1'b0;
      fetch_valid = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fetch_data  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      byte_cnt <= '0;
      word     <= '0;
      wrap     <= 1'b0;
      fetch_q  <= '0;
    end else begin
      if (fetch_valid) fetch_q <= bus.mem_rdata;
      if (sess) begin
        wr_ptr   <= '0;
        byte_cnt <= '0;
        word     <= '0;
        wrap     <= 1'b0;
      end
      if (accept) begin
        word[{byte_cnt, 3'b000} +: 8] <= bus.ld_byte;
        byte_cnt <= byte_cnt + 2'd1;
      end
      // cleared word gives zero padding for a later partial flush
      if (wr_fire) begin
        word   <= '0;
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_ptr == ADDR_W'(DEPTH - 1)) wrap <= 1'b1;
      end
    end
  end

  assign busy = (state == LOAD) || (state == WRITE) || (state == FLUSH);

  assign bus.cpu_stall   = bus.ld_mode | (~rst & busy);
  assign bus.ld_ready    = ld_ready;
  assign bus.ld_wrap     = wrap & ~rst;
  assign bus.fetch_ready = fetch_ready;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_data  = fetch_data;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

`ifdef IMEM_ARB_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst)         csum <= 8'h00;
    else if (sess)   csum <= 8'h00;
    else if (accept) csum <= csum + bus.ld_byte;
  end

  assign bus.ld_checksum = rst ? 8'h00 : csum;
`else
  assign bus.ld_checksum = 8'h00;
`endif
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: randomized scoreboard bench with a word-level
// reference model of the loader sessions and the instruction RAM.
module tb_imem_load_arbiter;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_load_arbiter_if #(.ADDR_W(AW)) bus ();

  imem_load_arbiter #(
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_fd[$];
  logic [7:0]  stim[$];

  logic [31:0] ram[DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem[DEPTH];

  logic [7:0] sbytes[$];
  int         sptr;
  int         swrites;
  logic [7:0] ssum;

  function automatic void m_start();
    sbytes.delete();
    sptr    = 0;
    swrites = 0;
    ssum    = 8'h00;
  endfunction

  function automatic void m_emit();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < sbytes.size(); i++) w[8*i +: 8] = sbytes[i];
    exp_wr.push_back({AW'(sptr), w});
    ref_mem[sptr] = w;
    sptr = (sptr + 1) % DEPTH;
    swrites++;
    sbytes.delete();
  endfunction

  function automatic void m_byte(logic [7:0] b);
    sbytes.push_back(b);
    ssum = ssum + b;
    if (sbytes.size() == 4) m_emit();
  endfunction

  function automatic void m_end();
    if (sbytes.size() != 0) m_emit();
  endfunction

  function automatic logic [7:0] exp_csum();
`ifdef IMEM_ARB_CHECKSUM_EN
    return ssum;
`else
    return 8'h00;
`endif
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  wr_t         mon_w;
  logic [31:0] mon_d;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (exp_wr.size() == 0) begin
        chk("write_unexpected", 32'd1, 32'd0);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(mon_w.addr));
        chk("write_data", bus.mem_wdata, mon_w.data);
      end
    end
    if (bus.fetch_valid) begin
      if (exp_fd.size() == 0) begin
        chk("fetch_unexpected", 32'd1, 32'd0);
      end else begin
        mon_d = exp_fd.pop_front();
        chk("fetch_data", bus.fetch_data, mon_d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input bit from_stim, input bit drop,
                      output int tail);
    int got;
    int guard;
    logic [7:0] b;
    got   = 0;
    guard = 0;
    tail  = 0;
    m_start();
    bus.ld_mode = 1'b1;
    b = from_stim ? stim.pop_front() : 8'($urandom);
    while (got < n && guard < 8 * n + 20) begin
      bus.ld_valid = ($urandom_range(0, 3) != 0);
      bus.ld_byte  = b;
      @(negedge clk);
      if (bus.ld_valid && bus.ld_ready) begin
        m_byte(b);
        got++;
        if (got < n) b = from_stim ? stim.pop_front() : 8'($urandom);
      end
      tick();
      guard++;
    end
    bus.ld_valid = 1'b0;
    if (got < n) chk("load_timeout", 32'(got), 32'(n));
    if (drop) begin
      bus.ld_mode = 1'b0;
      m_end();
      do begin
        @(negedge clk);
        tail++;
      end while (bus.cpu_stall && tail < 10);
      chk("stall_release", 32'(bus.cpu_stall), 32'd0);
      chk("checksum", 32'(bus.ld_checksum), 32'(exp_csum()));
      chk("wrap", 32'(bus.ld_wrap), 32'(swrites >= DEPTH));
      tick();
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input bit raise_ld);
    int guard;
    bit acc;
    logic [31:0] e;
    guard = 0;
    acc   = 1'b0;
    e     = 32'h0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    while (!acc && guard < 10) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        acc = 1'b1;
        e   = ref_mem[a];
        exp_fd.push_back(e);
      end
      tick();
      guard++;
    end
    bus.fetch_req = 1'b0;
    if (!acc) chk("fetch_timeout", 32'd0, 32'd1);
    if (raise_ld) bus.ld_mode = 1'b1;
    @(negedge clk);
    chk("fetch_latency", 32'(bus.fetch_valid), 32'(acc));
    chk("fetch_ready_busy", 32'(bus.fetch_ready), 32'd0);
    tick();
    if (!raise_ld) begin
      @(negedge clk);
      chk("fetch_hold", bus.fetch_data, e);
      chk("fetch_pulse", 32'(bus.fetch_valid), 32'd0);
      tick();
    end
  endtask

  task automatic fetch_burst(input int n);
    int got;
    int now;
    int last;
    got  = 0;
    now  = 0;
    last = -1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'($urandom);
    while (got < n && now < 4 * n + 10) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        exp_fd.push_back(ref_mem[bus.fetch_addr]);
        if (last >= 0) chk("burst_interval", 32'(now - last), 32'd2);
        last = now;
        got++;
      end
      tick();
      now++;
      bus.fetch_addr = AW'($urandom);
    end
    bus.fetch_req = 1'b0;
    if (got < n) chk("burst_timeout", 32'(got), 32'(n));
    tick();
  endtask

  task automatic chk_rst_outs();
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_ld_wrap", 32'(bus.ld_wrap), 32'd0);
    chk("rst_checksum", 32'(bus.ld_checksum), 32'd0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_data", bus.fetch_data, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #300000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    int tail;
    logic [7:0] tbl[8];
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    bus.ld_mode    = 1'b1;
    bus.ld_valid   = 1'b0;
    bus.ld_byte    = 8'h00;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    rst = 1'b1;

    @(negedge clk);
    chk_rst_outs();
    chk("rst_stall_hi", 32'(bus.cpu_stall), 32'd1);
    bus.ld_mode = 1'b0;
    @(negedge clk);
    chk("rst_stall_lo", 32'(bus.cpu_stall), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    foreach (tbl[i]) stim.push_back(tbl[i]);
    load(8, 1'b1, 1'b1, tail);
    chk("ram_word0", ram[0], 32'h44332211);
    chk("ram_word1", ram[1], 32'h88776655);

    fetch(AW'(1), 1'b0);
    chk("fetch_word1", bus.fetch_data, 32'h88776655);
    fetch_burst(4);

    bus.ld_mode    = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(3);
    @(negedge clk);
    chk("arb_no_fetch", 32'(bus.fetch_ready), 32'd0);
    chk("arb_stall", 32'(bus.cpu_stall), 32'd1);
    tick();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("arb_in_load", 32'(bus.ld_ready), 32'd1);
    tick();
    load(4, 1'b0, 1'b1, tail);

    fetch(AW'($urandom), 1'b1);
    load(3, 1'b0, 1'b1, tail);

    tbl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) stim.push_back(tbl[i]);
    load(5, 1'b1, 1'b1, tail);
    chk("flush_tail", 32'(tail), 32'd3);
    chk("flush_word0", ram[0], 32'hDDCCBBAA);
    chk("flush_word1", ram[1], 32'h000000EE);

    for (int i = 0; i <= DEPTH; i++) begin
      stim.push_back(8'(i));
      repeat (3) stim.push_back(8'h00);
    end
    load(4 * (DEPTH + 1), 1'b1, 1'b1, tail);
    chk("wrap_word0", ram[0], 32'd32);
    chk("wrap_word31", ram[31], 32'd31);

    load(2, 1'b0, 1'b0, tail);
    rst = 1'b1;
    bus.ld_mode = 1'b0;
    sbytes.delete();
    @(negedge clk);
    chk("rst_mid_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mid_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_rst_outs();
    tick();
    load(4, 1'b0, 1'b1, tail);

    for (int k = 0; k < 15; k++) begin
      case ($urandom_range(0, 2))
        0: fetch(AW'($urandom), 1'b0);
        1: fetch_burst(int'($urandom_range(2, 4)));
        default: load(int'($urandom_range(1, 14)), 1'b0, 1'b1, tail);
      endcase
    end

    repeat (3) tick();
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("fd_queue_empty", 32'(exp_fd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_load_arbiter.md
# imem_load_arbiter

Shares the single-port instruction memory between the CPU fetch path and the byte-serial external program loader. While loading, it stalls the CPU and packs incoming bytes into 32-bit little-endian words, writing them to sequential word addresses. When no load is in progress it serves CPU fetch requests with a fixed two-cycle handshake. It sits between the top-level pin interface, the CPU fetch port and the instruction RAM.

## Interface
- DEPTH, 32: instruction memory depth in 32-bit words; power of two.
- ADDR_W, $clog2(DEPTH): word-address width.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset: synchronous, active-high. This is already decided.
- ld_mode  in  1  level; high requests loader ownership of the memory.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte.
- ld_ready  out  1  byte accepted when ld_valid && ld_ready.
- ld_wrap  out  1  sticky; the write pointer wrapped during this session.
- ld_checksum  out  8  session byte checksum (see Configuration).
- fetch_req  in  1  CPU fetch request.
- fetch_addr  in  ADDR_W  CPU word address.
- fetch_ready  out  1  fetch_req is accepted this cycle.
- fetch_valid  out  1  one-cycle pulse; fetch_data is valid.
- fetch_data  out  32  fetched instruction word.
- cpu_stall  out  1  CPU must hold its PC.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; synchronous, valid one cycle after the address.

## Operation
- States: IDLE, FETCH, LOAD, WRITE, FLUSH.
- IDLE:
  - ld_mode=1 → LOAD. On entry: wr_ptr=0, byte_cnt=0, ld_wrap=0, checksum=0.
  - Otherwise, if fetch_req=1 → FETCH. In that cycle mem_addr=fetch_addr and fetch_ready=1.
  - If ld_mode and fetch_req are both high, the loader wins and fetch_ready=0.
- FETCH (always one cycle, never aborted):
  - fetch_valid=1 and fetch_data=mem_rdata.
  - Next state: LOAD if ld_mode=1 (with the session-entry clears above), else IDLE.
- LOAD:
  - ld_ready=1.
  - On each accepted byte, the byte is stored at word bits [8*byte_cnt+7 : 8*byte_cnt] and byte_cnt increments.
  - The 4th accepted byte → WRITE, with byte_cnt=0.
  - ld_mode=0 with byte_cnt≠0 → FLUSH. ld_mode=0 with byte_cnt=0 → IDLE.
  - A byte presented in the same cycle that ld_mode falls is not accepted; ld_ready is gated by ld_mode.
- WRITE (one cycle):
  - mem_we=1, mem_addr=wr_ptr, mem_wdata=the assembled word, ld_ready=0.
  - wr_ptr increments modulo DEPTH. If wr_ptr moves from DEPTH-1 to 0, ld_wrap is set.
  - Next state: LOAD if ld_mode=1, else IDLE.
- FLUSH (one cycle): writes the partial word with unreceived upper bytes zero, increments wr_ptr as in WRITE, then goes to IDLE.
- Stall and default outputs:
  - cpu_stall = ld_mode || state ∈ {LOAD, WRITE, FLUSH}.
  - fetch_ready=0 outside IDLE.
  - mem_we=0 outside WRITE and FLUSH.
  - mem_addr=wr_ptr in LOAD.

## Timing
- Reset values: state=IDLE, wr_ptr=0, byte_cnt=0, assembled word=0.
- Outputs at reset: ld_ready=0, ld_wrap=0, ld_checksum=0, fetch_ready=0, fetch_valid=0, fetch_data=0, mem_we=0, mem_addr=0, mem_wdata=0.
- cpu_stall during reset follows ld_mode.
- Fetch latency: request accepted in cycle N, fetch_valid in N+1. Peak rate is one fetch every 2 cycles.
- Load throughput: 4 accept cycles plus 1 WRITE cycle per word. The 5th byte can be accepted at the earliest in the cycle after WRITE.
- fetch_data holds its last value when fetch_valid=0.
- rst asserted mid-load or mid-fetch: the partial word is discarded, no write occurs, and the FSM returns to IDLE on the next edge.

## Configuration
- IMEM_ARB_CHECKSUM_EN defined:
  - ld_checksum = 8-bit modular sum of all bytes accepted in the current session.
  - It is cleared at session entry and holds after the session ends.
  - FLUSH padding bytes are not counted.
- IMEM_ARB_CHECKSUM_EN undefined: the ld_checksum port remains and is tied to 8'h00. No adder is synthesized.

## Test plan
- Load 8 bytes 11,22,33,44,55,66,77,88, then drop ld_mode:
  - memory word 0 = 0x44332211 and word 1 = 0x88776655;
  - ld_wrap=0;
  - with the macro, checksum = 0x64.
- Load 5 bytes AA,BB,CC,DD,EE, then drop ld_mode:
  - FLUSH writes word 1 = 0x000000EE;
  - cpu_stall deasserts the cycle after FLUSH.
- After the load, fetch_req with fetch_addr=1:
  - fetch_ready in cycle N;
  - fetch_valid=1 with fetch_data=0x88776655 in N+1;
  - back-to-back fetches are accepted every 2 cycles.
- Raise ld_mode and fetch_req in the same IDLE cycle:
  - fetch_ready=0 and the FSM enters LOAD.
  - Separately, raise ld_mode during FETCH: fetch_valid still pulses, then LOAD.
- Stream DEPTH+1 words (DEPTH=32) with word i = i:
  - word 0 ends at value 32 (overwritten);
  - ld_wrap=1 after the 32nd WRITE.
- Assert rst after 2 bytes:
  - no mem_we pulse;
  - all outputs at their reset values next cycle;
  - a new session restarts at wr_ptr=0.
